// File: rtl/pe_ifmap_feeder_if.sv
// Bundle of the feeder's control, global-buffer read port and PE-side signals.
// master: the PE controller and SRAM side; slave: the feeder itself.
interface pe_ifmap_feeder_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 12
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] run_len;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              data_read;
    logic [DATA_W-1:0] pe_data;
    logic              stop_read;
    logic              data_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, run_len, mem_rdata, data_read,
        input  mem_rd, mem_addr, pe_data, stop_read, data_ready, busy, done
    );

    modport slave (
        input  start, base_addr, run_len, mem_rdata, data_read,
        output mem_rd, mem_addr, pe_data, stop_read, data_ready, busy, done
    );
endinterface

// File: rtl/pe_ifmap_feeder.sv
// Streams a run of ifmap words from the global buffer into a circular FIFO
// and serves the PE controller's per-cycle pops.
module pe_ifmap_feeder #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned STRIDE = 1
) (
    input logic               clk,
    input logic               rst,
    pe_ifmap_feeder_if.slave  io_bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_occ;
    logic              r_inflight;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_base;
    logic [DATA_W-1:0] r_fifo [DEPTH];

    logic w_room;
    logic w_words_left;
    logic w_issue;
    logic w_last;
    logic w_fill;
    logic w_pop;

    // The in-flight read already owns a slot, so it counts against room.
    assign w_room       = (r_occ + CNT_W'(r_inflight)) < CNT_W'(DEPTH);
    assign w_words_left = r_issued < r_len;
    assign w_issue      = (r_state == StFetch) && w_room && w_words_left;
    assign w_last       = (r_issued + (ADDR_W + 1)'(1)) == r_len;
    assign w_fill       = r_inflight;
    assign w_pop        = io_bus.data_read && (r_occ != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_issued   <= '0;
            r_len      <= '0;
            r_base     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_fill) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_fill && !w_pop)      r_occ <= r_occ + CNT_W'(1);
            else if (!w_fill && w_pop) r_occ <= r_occ - CNT_W'(1);

            unique case (r_state)
                StIdle, StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (io_bus.start) begin
                        r_base   <= io_bus.base_addr;
                        r_len    <= {1'b0, io_bus.run_len};
                        r_issued <= '0;
                        if (io_bus.run_len != '0) begin
                            r_state <= StFetch;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    if (w_issue) begin
                        r_issued <= r_issued + (ADDR_W + 1)'(1);
                        if (w_last) r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (!r_inflight && (r_occ == '0)) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage is left unreset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (!rst && w_fill) r_fifo[r_wr_ptr] <= io_bus.mem_rdata;
    end

    assign io_bus.mem_rd     = w_issue;
    assign io_bus.mem_addr   = w_issue ? (r_base + r_issued[ADDR_W-1:0]) : '0;
    assign io_bus.pe_data    = (r_occ == '0) ? '0 : r_fifo[r_rd_ptr];
    assign io_bus.stop_read  = (r_occ == '0);
    assign io_bus.data_ready = (r_occ >= CNT_W'(STRIDE));
    assign io_bus.busy       = r_busy;
    assign io_bus.done       = r_done;
endmodule

// File: tb/tb_pe_ifmap_feeder.sv
// Self-checking bench: a queue-based model of the feeder is compared against the DUT every
// cycle, plus literal expectations for the directed scenarios.
module tb_pe_ifmap_feeder;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned STRIDE = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_ifmap_feeder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    pe_ifmap_feeder #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .STRIDE(STRIDE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SRAM content: each word is its address plus one, truncated to a byte.
    function automatic logic [7:0] sram(input int addr);
        int v;
        v = (addr + 1) & 32'hff;
        return v[7:0];
    endfunction

    always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? sram(int'(bus.mem_addr)) : 8'h00;

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 fetching, 2 draining, 3 done
    int         m_phase = 0;
    logic [7:0] m_q[$];
    bit         m_pend = 0;
    int         m_pend_addr = 0;
    int         m_issued = 0, m_len = 0, m_base = 0;
    bit         m_started = 0;

    function automatic bit exp_rd();
        return (m_phase == 1) && ((m_q.size() + int'(m_pend)) < DEPTH) && (m_issued < m_len);
    endfunction

    function automatic int exp_addr();
        return (m_base + m_issued) % (1 << ADDR_W);
    endfunction

    always @(posedge clk) begin : model
        bit rd, was_pend;
        int addr, was_size;
        rd = exp_rd();
        addr = exp_addr();
        was_pend = m_pend;
        was_size = m_q.size();
        if (rst) begin
            m_phase = 0; m_q.delete(); m_pend = 0; m_issued = 0; m_len = 0; m_base = 0;
        end else begin
            if (bus.data_read && m_q.size() > 0) void'(m_q.pop_front());
            if (m_pend) m_q.push_back(sram(m_pend_addr));
            m_pend = rd;
            m_pend_addr = addr;
            case (m_phase)
                0, 3: begin
                    if (bus.start) begin
                        m_base = int'(bus.base_addr);
                        m_len = int'(bus.run_len);
                        m_issued = 0;
                        m_phase = (m_len != 0) ? 1 : 3;
                    end else begin
                        m_phase = 0;
                    end
                end
                1: if (rd) begin
                    m_issued++;
                    if (m_issued == m_len) m_phase = 2;
                end
                2: if (!was_pend && was_size == 0) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
        m_started = 1;
    end

    // ---------------- per-cycle compare and monitors ----------------
    int         rd_count = 0;
    int         done_count = 0;
    logic [31:0] addr_log[$];
    logic [31:0] pop_log[$];

    always @(negedge clk) begin
        if (m_started) begin
            chk("mem_rd", 32'(bus.mem_rd), 32'(exp_rd()));
            if (exp_rd()) chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr()));
            chk("stop_read", 32'(bus.stop_read), 32'(m_q.size() == 0));
            chk("data_ready", 32'(bus.data_ready), 32'(m_q.size() >= STRIDE));
            chk("busy", 32'(bus.busy), 32'(m_phase == 1 || m_phase == 2));
            chk("done", 32'(bus.done), 32'(m_phase == 3));
            if (m_q.size() > 0) chk("pe_data", 32'(bus.pe_data), 32'(m_q[0]));
            if (bus.mem_rd === 1'b1) begin
                rd_count++;
                addr_log.push_back(32'(bus.mem_addr));
            end
            if (bus.data_read && bus.stop_read === 1'b0) pop_log.push_back(32'(bus.pe_data));
            if (bus.done === 1'b1) done_count++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int base, input int len);
        bus.base_addr = ADDR_W'(base);
        bus.run_len   = ADDR_W'(len);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (bus.done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int rd0, done0, a0, p0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.data_read = 1'b0;
        bus.base_addr = '0;
        bus.run_len = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        chk("rst_stop_read", 32'(bus.stop_read), 32'd1);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_pe_data", 32'(bus.pe_data), 32'd0);
        chk("rst_data_ready", 32'(bus.data_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        repeat (3) tick();
        chk("idle_no_rd", 32'(rd_count), 32'd0);

        // Basic run with data_read held
        a0 = addr_log.size(); p0 = pop_log.size(); done0 = done_count;
        bus.data_read = 1'b1;
        start_run(12'h010, 4);
        wait_done(40);
        tick();
        tick();
        chk("basic_done_once", 32'(done_count - done0), 32'd1);
        chk("basic_busy_low", 32'(bus.busy), 32'd0);
        chk("basic_n_addr", 32'(addr_log.size() - a0), 32'd4);
        chk("basic_n_pop", 32'(pop_log.size() - p0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (a0 + i < addr_log.size()) chk("basic_addr", addr_log[a0 + i], 32'h010 + 32'(i));
            if (p0 + i < pop_log.size()) chk("basic_pop", pop_log[p0 + i], 32'h11 + 32'(i));
        end
        bus.data_read = 1'b0;

        // Backpressure: 12 words into an 8-deep FIFO with no pops
        rd0 = rd_count; p0 = pop_log.size();
        start_run(12'h020, 12);
        chk("lat_mem_rd", 32'(bus.mem_rd), 32'd1);
        chk("lat_mem_addr", 32'(bus.mem_addr), 32'h020);
        tick();
        chk("lat_still_empty", 32'(bus.stop_read), 32'd1);
        tick();
        chk("lat_first_word", 32'(bus.stop_read), 32'd0);
        chk("lat_first_data", 32'(bus.pe_data), 32'h21);
        repeat (20) tick();
        chk("bp_reads_capped", 32'(rd_count - rd0), 32'd8);
        chk("bp_mem_rd_low", 32'(bus.mem_rd), 32'd0);
        chk("bp_data_ready", 32'(bus.data_ready), 32'd1);
        chk("bp_stop_read", 32'(bus.stop_read), 32'd0);
        start_run(12'h300, 2);  // must be ignored while fetching
        bus.data_read = 1'b1;
        wait_done(80);
        tick();
        chk("bp_reads_total", 32'(rd_count - rd0), 32'd12);
        chk("bp_n_pop", 32'(pop_log.size() - p0), 32'd12);
        for (int i = 0; i < 12; i++)
            if (p0 + i < pop_log.size()) chk("bp_pop_order", pop_log[p0 + i], 32'h21 + 32'(i));
        bus.data_read = 1'b0;

        // Fill and pop in the same cycle at occupancy 3, STRIDE 4
        start_run(12'h100, 12);
        repeat (4) tick();
        chk("sim_pre_ready", 32'(bus.data_ready), 32'd0);
        chk("sim_pre_head", 32'(bus.pe_data), 32'h01);
        bus.data_read = 1'b1;
        tick();
        bus.data_read = 1'b0;
        chk("sim_ready_held", 32'(bus.data_ready), 32'd0);
        chk("sim_head_advanced", 32'(bus.pe_data), 32'h02);
        tick();
        chk("sim_ready_after_fill", 32'(bus.data_ready), 32'd1);
        bus.data_read = 1'b1;
        wait_done(80);
        tick();
        bus.data_read = 1'b0;

        // Pop while empty is ignored
        bus.data_read = 1'b1;
        repeat (3) tick();
        chk("empty_pop_stop", 32'(bus.stop_read), 32'd1);
        chk("empty_pop_ready", 32'(bus.data_ready), 32'd0);
        chk("empty_pop_busy", 32'(bus.busy), 32'd0);
        bus.data_read = 1'b0;

        // Zero-length run
        rd0 = rd_count;
        start_run(12'h040, 0);
        chk("zero_done", 32'(bus.done), 32'd1);
        chk("zero_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("zero_done_pulse", 32'(bus.done), 32'd0);
        chk("zero_no_rd", 32'(rd_count - rd0), 32'd0);

        // Reset the cycle after a read; the returning word must be dropped
        start_run(12'h050, 6);
        chk("mrst_rd", 32'(bus.mem_rd), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_stop", 32'(bus.stop_read), 32'd1);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_mem_rd", 32'(bus.mem_rd), 32'd0);
        tick();
        chk("mrst_discard", 32'(bus.stop_read), 32'd1);
        tick();
        chk("mrst_discard2", 32'(bus.stop_read), 32'd1);
        a0 = addr_log.size(); p0 = pop_log.size();
        bus.data_read = 1'b1;
        start_run(12'h070, 3);
        wait_done(40);
        tick();
        bus.data_read = 1'b0;
        chk("mrst_n_pop", 32'(pop_log.size() - p0), 32'd3);
        if (a0 < addr_log.size()) chk("mrst_first_addr", addr_log[a0], 32'h070);
        for (int i = 0; i < 3; i++)
            if (p0 + i < pop_log.size()) chk("mrst_pop", pop_log[p0 + i], 32'h71 + 32'(i));

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
